// File: rtl/fxp_calc_core_seq_pkg.sv
// Shared definitions for the sequential Q9.6 sign-magnitude calculator core:
// word layout, opcodes, FSM encodings and the result packing helper.
package fxp_calc_core_seq_pkg;

    localparam int INT_BITS  = 9;
    localparam int FRAC_BITS = 6;
    localparam int M         = INT_BITS + FRAC_BITS;
    localparam int W         = M + 1;
    localparam int PROD_W    = 2 * M;
    localparam int QUO_W     = M + FRAC_BITS;
    localparam int MUL_ITER  = M;
    localparam int DIV_ITER  = M + FRAC_BITS;

    localparam logic [M-1:0] SAT_MAG = 15'h7FFF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic         sign;
        logic [M-1:0] mag;
    } fxp_t;

    // A zero magnitude always carries a positive sign, so -0 never escapes.
    function automatic fxp_t make_fxp(input logic sign, input logic [M-1:0] mag);
        fxp_t r;
        r.sign = sign & (mag != '0);
        r.mag  = mag;
        return r;
    endfunction

endpackage

// File: rtl/fxp_calc_core_seq_muldiv.sv
// Iterative unsigned engine on 15-bit magnitudes: shift-add multiplier (LSB of b first)
// or restoring divider of a<<FRAC_BITS by b (one quotient bit per cycle, MSB first).
module fxp_calc_core_seq_muldiv
    import fxp_calc_core_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       is_div,
    input  logic [M-1:0]               a_mag,
    input  logic [M-1:0]               b_mag,
    output logic                       finish,
    output logic [PROD_W-FRAC_BITS-1:0] prod_trunc,
    output logic [QUO_W-1:0]           quotient
);

    logic [4:0]        cnt_reg;
    logic              is_div_reg;
    logic [PROD_W-1:0] prod_reg;
    logic [PROD_W-1:0] mcand_reg;
    logic [M-1:0]      mplier_reg;
    logic [M-1:0]      divisor_reg;
    logic [M-1:0]      rem_reg;
    logic [QUO_W-1:0]  quo_reg;

    logic [4:0] target;
    logic [M:0] shifted;
    logic       ge;
    logic [M-1:0] diff;

    assign target  = is_div_reg ? 5'(DIV_ITER) : 5'(MUL_ITER);
    assign finish  = (cnt_reg == target);

    // Remainder stays below the divisor, so the low M bits of the difference are exact.
    assign shifted = {rem_reg, quo_reg[QUO_W-1]};
    assign ge      = (shifted >= {1'b0, divisor_reg});
    assign diff    = shifted[M-1:0] - divisor_reg;

    assign prod_trunc = prod_reg[PROD_W-1:FRAC_BITS];
    assign quotient   = quo_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            prod_reg    <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
        end else if (load) begin
            cnt_reg     <= '0;
            is_div_reg  <= is_div;
            prod_reg    <= '0;
            mcand_reg   <= {{(PROD_W-M){1'b0}}, a_mag};
            mplier_reg  <= b_mag;
            divisor_reg <= b_mag;
            rem_reg     <= '0;
            quo_reg     <= {a_mag, {FRAC_BITS{1'b0}}};
        end else if (!finish) begin
            cnt_reg <= cnt_reg + 5'd1;
            if (is_div_reg) begin
                rem_reg <= ge ? diff : shifted[M-1:0];
                quo_reg <= {quo_reg[QUO_W-2:0], ge};
            end else begin
                if (mplier_reg[0]) begin
                    prod_reg <= prod_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
            end
        end
    end

endmodule

// File: rtl/fxp_calc_core_seq.sv
// Sequential Q9.6 sign-magnitude arithmetic core: FSM, add/sub path, sign handling,
// saturation and the registered result/flag outputs.
module fxp_calc_core_seq
    import fxp_calc_core_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         ovf,
    output logic         div0
);

    logic [1:0] state_reg, state_next;
    fxp_t       a_reg, b_reg;
    logic [1:0] op_reg;
    logic       tick_reg;
    fxp_t       result_reg;
    logic       ovf_reg, div0_reg;

    logic       accept;
    logic       skip;
    logic       exec_end;
    logic       md_finish;
    logic [PROD_W-FRAC_BITS-1:0] md_prod;
    logic [QUO_W-1:0]            md_quo;

    logic       b_sign_eff;
    logic [M:0] sum;
    logic       sign_next;
    logic [M-1:0] mag_next;
    logic       ovf_next, div0_next;

    assign accept = (state_reg == ST_IDLE) && start;

    // ADD/SUB and divide-by-zero finish after a single execute cycle.
    assign skip     = (op_reg == OP_ADD) || (op_reg == OP_SUB) ||
                      ((op_reg == OP_DIV) && (b_reg.mag == '0));
    assign exec_end = skip ? tick_reg : md_finish;

    fxp_calc_core_seq_muldiv u_muldiv (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .is_div     (op == OP_DIV),
        .a_mag      (a_in[M-1:0]),
        .b_mag      (b_in[M-1:0]),
        .finish     (md_finish),
        .prod_trunc (md_prod),
        .quotient   (md_quo)
    );

    assign b_sign_eff = b_reg.sign ^ (op_reg == OP_SUB);
    assign sum        = {1'b0, a_reg.mag} + {1'b0, b_reg.mag};

    always_comb begin
        sign_next = 1'b0;
        mag_next  = '0;
        ovf_next  = 1'b0;
        div0_next = 1'b0;
        case (op_reg)
            OP_ADD, OP_SUB: begin
                if (a_reg.sign == b_sign_eff) begin
                    sign_next = a_reg.sign;
                    if (sum[M]) begin
                        mag_next = SAT_MAG;
                        ovf_next = 1'b1;
                    end else begin
                        mag_next = sum[M-1:0];
                    end
                end else if (a_reg.mag >= b_reg.mag) begin
                    sign_next = a_reg.sign;
                    mag_next  = a_reg.mag - b_reg.mag;
                end else begin
                    sign_next = b_sign_eff;
                    mag_next  = b_reg.mag - a_reg.mag;
                end
            end
            OP_MUL: begin
                sign_next = a_reg.sign ^ b_reg.sign;
                if (|md_prod[PROD_W-FRAC_BITS-1:M]) begin
                    mag_next = SAT_MAG;
                    ovf_next = 1'b1;
                end else begin
                    mag_next = md_prod[M-1:0];
                end
            end
            default: begin
                if (b_reg.mag == '0) begin
                    div0_next = 1'b1;
                end else begin
                    sign_next = a_reg.sign ^ b_reg.sign;
                    if (|md_quo[QUO_W-1:M]) begin
                        mag_next = SAT_MAG;
                        ovf_next = 1'b1;
                    end else begin
                        mag_next = md_quo[M-1:0];
                    end
                end
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)    state_next = ST_EXEC;
            ST_EXEC: if (exec_end) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= OP_ADD;
            tick_reg   <= 1'b0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            div0_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg    <= a_in;
                b_reg    <= b_in;
                op_reg   <= op;
                tick_reg <= 1'b0;
                ovf_reg  <= 1'b0;
                div0_reg <= 1'b0;
            end
            if (state_reg == ST_EXEC) begin
                tick_reg <= 1'b1;
                if (exec_end) begin
                    result_reg <= make_fxp(sign_next, mag_next);
                    ovf_reg    <= ovf_next;
                    div0_reg   <= div0_next;
                end
            end
        end
    end

    assign result = result_reg;
    assign done   = (state_reg == ST_DONE);
    assign busy   = (state_reg != ST_IDLE);
    assign ovf    = ovf_reg;
    assign div0   = div0_reg;

endmodule

// File: tb/tb_fxp_calc_core_seq.sv
// Self-checking bench for fxp_calc_core_seq: directed cases plus random operations
// compared against a signed-integer reference model of Q9.6 arithmetic.
module tb_fxp_calc_core_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a_in, b_in;
    logic [15:0] result;
    logic        done, busy, ovf, div0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fxp_calc_core_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .result (result),
        .done   (done),
        .busy   (busy),
        .ovf    (ovf),
        .div0   (div0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Values as signed counts of 1/64; saturation at 32767 counts.
    function automatic void model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic e_ovf, output logic e_div0,
                                  output int lat);
        longint va, vb, s, mag;
        logic   neg;
        logic [15:0] m16;
        e_ovf = 1'b0; e_div0 = 1'b0; neg = 1'b0; mag = 0;
        va = a[15] ? -longint'(a[14:0]) : longint'(a[14:0]);
        vb = b[15] ? -longint'(b[14:0]) : longint'(b[14:0]);
        case (o)
            2'b00, 2'b01: begin
                lat = 2;
                s   = (o == 2'b01) ? va - vb : va + vb;
                neg = (s < 0);
                mag = neg ? -s : s;
            end
            2'b10: begin
                lat = 16;
                neg = a[15] ^ b[15];
                mag = (longint'(a[14:0]) * longint'(b[14:0])) / 64;
            end
            default: begin
                if (b[14:0] == 0) begin
                    lat = 2; e_div0 = 1'b1;
                end else begin
                    lat = 22;
                    neg = a[15] ^ b[15];
                    mag = (longint'(a[14:0]) * 64) / longint'(b[14:0]);
                end
            end
        endcase
        if (mag > 32767) begin
            mag = 32767; e_ovf = 1'b1;
        end
        m16 = 16'(mag);
        r = {neg && (mag != 0), m16[14:0]};
    endfunction

    // Issue one operation; optionally hammer start while busy and during the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit poke);
        logic [15:0] er; logic eo, ed; int lat; int k;
        model(o, a, b, er, eo, ed, lat);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
        check("busy_after_accept", busy, 1'b1);
        check("ovf_clear_on_accept", ovf, 1'b0);
        check("div0_clear_on_accept", div0, 1'b0);
        k = 0;
        while (k < 40) begin
            if (poke) begin
                start = 1'b1; op = 2'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
            end
            @(posedge clk); #1;
            k++;
            if (done) break;
        end
        check("latency", k, lat);
        check("result", result, er);
        check("ovf", ovf, eo);
        check("div0", div0, ed);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_single_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("result_held", result, er);
        $display("op=%0d a=%h b=%h -> result=%h ovf=%0b div0=%0b latency=%0d (exp %h/%0b/%0b/%0d)",
                 o, a, b, result, ovf, div0, k, er, eo, ed, lat);
    endtask

    initial begin
        int ndone;
        logic [15:0] ra, rb;
        logic [1:0]  ro;

        rst = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 16'h0000);
        check("reset_done", done, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        check("reset_div0", div0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'b00, 16'h0060, 16'h0090, 1'b0);
        run_op(2'b01, 16'h0060, 16'h0090, 1'b0);
        run_op(2'b01, 16'h0060, 16'h0060, 1'b0);
        run_op(2'b10, 16'h8080, 16'h00C0, 1'b0);
        run_op(2'b10, 16'h1000, 16'h1000, 1'b0);
        run_op(2'b11, 16'h0090, 16'h0060, 1'b0);
        run_op(2'b11, 16'h0040, 16'h8000, 1'b0);
        run_op(2'b00, 16'h7FC0, 16'h0040, 1'b0);
        run_op(2'b00, 16'h0040, 16'h0040, 1'b0);
        run_op(2'b00, 16'h8100, 16'h0100, 1'b0);
        run_op(2'b11, 16'h7FFF, 16'h0001, 1'b0);

        // start asserted throughout busy and during the done cycle
        run_op(2'b11, 16'h8123, 16'h0045, 1'b1);
        run_op(2'b10, 16'h0321, 16'h8077, 1'b1);

        // reset in the middle of a division
        op = 2'b11; a_in = 16'h0200; b_in = 16'h0030; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_result", result, 16'h0000);
        check("midrst_done", done, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        check("midrst_div0", div0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        $display("reset mid-DIV: result=%h busy=%0b done_pulses=%0d", result, busy, ndone);
        run_op(2'b00, 16'h0123, 16'h8040, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ro = 2'($urandom);
            ra = {1'($urandom), 15'($urandom_range(0, 32767) >> $urandom_range(0, 14))};
            rb = {1'($urandom), 15'($urandom_range(0, 32767) >> $urandom_range(0, 14))};
            if ($urandom_range(0, 9) == 0) rb[14:0] = '0;
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
